esc_multi_drive: RTL and testbench



---
 rtl/motor_drive_pkg.sv | 23 ++
 rtl/esc_pulse_channel.sv | 104 ++++++++++
 rtl/esc_multi_drive.sv | 151 +++++++++++++++
 tb/tb_esc_multi_drive.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_drive_pkg.sv
// Shared types and helpers for the multi-channel ESC drive.
// Holds the drive state encoding and the throttle-to-pulse-width mapping,
// so the RTL and any reference model compute pulse widths identically.
package motor_drive_pkg;

  localparam int DRIVE_STATE_W = 2;

  typedef enum logic [DRIVE_STATE_W-1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    FAULT    = 2'd3
  } drive_state_t;

  // Pulse width in clocks for a ramped command: min width plus the scaled span.
  function automatic int pulse_width(input int ramped_val, input int cmd_w,
                                     input int pulse_min, input int pulse_span);
    longint prod;
    prod = longint'(ramped_val) * longint'(pulse_span);
    return pulse_min + int'(prod >> cmd_w);
  endfunction

endpackage

// File: rtl/esc_pulse_channel.sv
// One ESC channel: target register, frame-synchronous slew limiter,
// per-frame pulse-width latch and pulse comparator.
// Optional feature macro: MOTOR_ASYM_RAMP_EN (separate ramp-down step RAMP_STEP_DN).
module esc_pulse_channel
  import motor_drive_pkg::*;
#(
  parameter int CMD_W          = 12,
  parameter int PULSE_MIN_CYC  = 50000,
  parameter int PULSE_SPAN_CYC = 50000,
  parameter int RAMP_STEP      = 64,
`ifdef MOTOR_ASYM_RAMP_EN
  parameter int RAMP_STEP_DN   = 256,
`endif
  parameter int CNT_W          = 20
) (
  input  logic             c50m,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             ramp_en,
  input  logic             clr,
  input  logic             out_en,
  input  logic             brake,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd_in,
  input  logic [CNT_W-1:0] frame_cnt,
  output logic             pwm_out,
  output logic [CMD_W-1:0] ramped,
  output logic             target_zero
);

`ifdef MOTOR_ASYM_RAMP_EN
  localparam int STEP_DN_I = RAMP_STEP_DN;
`else
  localparam int STEP_DN_I = RAMP_STEP;
`endif
  // Steps are saturated to the CMD_W+1 bit ramp arithmetic range.
  localparam int R_MAX       = (2 ** (CMD_W + 1)) - 1;
  localparam int STEP_UP_SAT = (RAMP_STEP > R_MAX) ? R_MAX : RAMP_STEP;
  localparam int STEP_DN_SAT = (STEP_DN_I > R_MAX) ? R_MAX : STEP_DN_I;
  localparam logic [CMD_W:0] STEP_UP = STEP_UP_SAT[CMD_W:0];
  localparam logic [CMD_W:0] STEP_DN = STEP_DN_SAT[CMD_W:0];
  localparam int PW_W  = $clog2(PULSE_MIN_CYC + PULSE_SPAN_CYC + 1);
  localparam int CMP_W = (PW_W > CNT_W) ? PW_W : CNT_W;

  logic [CMD_W-1:0] target_q, target_d;
  logic [CMD_W-1:0] ramped_q, ramped_d;
  logic [CMP_W-1:0] pw_lat_q, pw_lat_d;
  logic             pwm_q, pwm_d;
  logic [CMD_W:0]   tgt_w, cur_w, diff_w, stepped_w;
  logic [CMP_W-1:0] cnt_ext;
  int               pw_int;

  // Slew limiter: move toward the target by at most one step, never past it.
  always_comb begin
    tgt_w     = {1'b0, target_q};
    cur_w     = {1'b0, ramped_q};
    diff_w    = '0;
    stepped_w = cur_w;
    if (tgt_w > cur_w) begin
      diff_w    = tgt_w - cur_w;
      stepped_w = (diff_w > STEP_UP) ? (cur_w + STEP_UP) : tgt_w;
    end else begin
      diff_w    = cur_w - tgt_w;
      stepped_w = (diff_w > STEP_DN) ? (cur_w - STEP_DN) : tgt_w;
    end
  end

  // Next target, ramp value, latched width and pulse level.
  always_comb begin
    target_d = cmd_valid ? cmd_in : target_q;
    ramped_d = ramped_q;
    if (clr) begin
      ramped_d = '0;
    end else if (ramp_en) begin
      ramped_d = brake ? '0 : stepped_w[CMD_W-1:0];
    end
    pw_int   = pulse_width(int'(ramped_d), CMD_W, PULSE_MIN_CYC, PULSE_SPAN_CYC);
    // Width for the new frame is used already in the tick cycle so the
    // pulse starts exactly at frame start; mid-frame it is frozen.
    pw_lat_d = tick ? pw_int[CMP_W-1:0] : pw_lat_q;
    cnt_ext  = CMP_W'(frame_cnt);
    pwm_d    = out_en && (cnt_ext < pw_lat_d);
  end

  // Channel state registers.
  always_ff @(posedge c50m or negedge reset_n) begin
    if (!reset_n) begin
      target_q <= '0;
      ramped_q <= '0;
      pw_lat_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      ramped_q <= ramped_d;
      pw_lat_q <= pw_lat_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign ramped      = ramped_q;
  assign target_zero = (target_q == '0);

endmodule

// File: rtl/esc_multi_drive.sv
// Multi-channel throttle-to-ESC drive: frame counter, command timeout,
// arm/disarm/failsafe FSM and NUM_CH slew-limited pulse channels.
// Optional feature macro: MOTOR_ASYM_RAMP_EN (adds RAMP_STEP_DN).
module esc_multi_drive
  import motor_drive_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int CMD_W          = 12,
  parameter int FRAME_CYC      = 1000000,
  parameter int PULSE_MIN_CYC  = 50000,
  parameter int PULSE_SPAN_CYC = 50000,
  parameter int RAMP_STEP      = 64,
`ifdef MOTOR_ASYM_RAMP_EN
  parameter int RAMP_STEP_DN   = 256,
`endif
  parameter int ARM_FRAMES     = 50,
  parameter int TIMEOUT_FRAMES = 10
) (
  input  logic                     c50m,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  input  logic [NUM_CH*CMD_W-1:0]  cmd,
  input  logic                     arm_req,
  input  logic                     brake,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic [NUM_CH*CMD_W-1:0]  ramped_cmd,
  output logic [DRIVE_STATE_W-1:0] drive_state,
  output logic                     frame_tick
);

  localparam int CNT_W = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_FRAMES + 1);
  localparam int AC_W  = $clog2(ARM_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYC - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_FRAMES);
  localparam logic [AC_W-1:0]  ARM_LAST = AC_W'(ARM_FRAMES);

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             frame_tick_q, frame_tick_d;
  logic [TO_W-1:0]  timeout_q, timeout_d;
  logic [AC_W-1:0]  arm_cnt_q, arm_cnt_d;
  drive_state_t     state_q, state_d;
  logic [NUM_CH-1:0] target_zero;
  logic             all_zero, ramp_en, clr, out_en;

  assign all_zero = &target_zero;

  // Frame counter, registered frame-start strobe and command timeout.
  always_comb begin
    frame_cnt_d  = (frame_cnt_q == CNT_LAST) ? '0 : frame_cnt_q + CNT_W'(1);
    frame_tick_d = (frame_cnt_d == '0);
    timeout_d    = timeout_q;
    if (cmd_valid) begin
      timeout_d = '0;
    end else if (frame_tick_q && (timeout_q != TO_MAX)) begin
      timeout_d = timeout_q + TO_W'(1);
    end
  end

  // Drive FSM: only an arm_req drop acts mid-frame, everything else waits for a frame start.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    case (state_q)
      DISARMED: begin
        arm_cnt_d = '0;
        if (frame_tick_q && arm_req && all_zero) state_d = ARMING;
      end
      ARMING: begin
        if (!arm_req) begin
          state_d   = DISARMED;
          arm_cnt_d = '0;
        end else if (frame_tick_q) begin
          if (!all_zero) begin
            state_d   = DISARMED;
            arm_cnt_d = '0;
          end else if ((arm_cnt_q + AC_W'(1)) == ARM_LAST) begin
            state_d   = ARMED;
            arm_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + AC_W'(1);
          end
        end
      end
      ARMED: begin
        if (!arm_req) state_d = DISARMED;
        else if (frame_tick_q && (timeout_d == TO_MAX)) state_d = FAULT;
      end
      FAULT: begin
        if (!arm_req) state_d = DISARMED;
      end
      default: state_d = DISARMED;
    endcase
  end

  // Ramping only while staying armed across a frame start; ramps are zero in every other state.
  assign ramp_en = frame_tick_q && (state_q == ARMED) && (state_d == ARMED);
  assign clr     = (state_d != ARMED);
  assign out_en  = (state_d != DISARMED);

  // Top-level state registers.
  always_ff @(posedge c50m or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q  <= '0;
      frame_tick_q <= 1'b0;
      timeout_q    <= '0;
      arm_cnt_q    <= '0;
      state_q      <= DISARMED;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      frame_tick_q <= frame_tick_d;
      timeout_q    <= timeout_d;
      arm_cnt_q    <= arm_cnt_d;
      state_q      <= state_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      esc_pulse_channel #(
        .CMD_W          (CMD_W),
        .PULSE_MIN_CYC  (PULSE_MIN_CYC),
        .PULSE_SPAN_CYC (PULSE_SPAN_CYC),
        .RAMP_STEP      (RAMP_STEP),
`ifdef MOTOR_ASYM_RAMP_EN
        .RAMP_STEP_DN   (RAMP_STEP_DN),
`endif
        .CNT_W          (CNT_W)
      ) u_ch (
        .c50m        (c50m),
        .reset_n     (reset_n),
        .tick        (frame_tick_q),
        .ramp_en     (ramp_en),
        .clr         (clr),
        .out_en      (out_en),
        .brake       (brake),
        .cmd_valid   (cmd_valid),
        .cmd_in      (cmd[gi*CMD_W +: CMD_W]),
        .frame_cnt   (frame_cnt_q),
        .pwm_out     (pwm_out[gi]),
        .ramped      (ramped_cmd[gi*CMD_W +: CMD_W]),
        .target_zero (target_zero[gi])
      );
    end
  endgenerate

  assign drive_state = state_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_esc_multi_drive.sv
// Directed self-checking bench for esc_multi_drive with small frame parameters.
// Optional feature macro: MOTOR_ASYM_RAMP_EN (adds the asymmetric ramp-down vectors).
module tb_esc_multi_drive;

  localparam int FR   = 1000;
  localparam int CW   = 8;
  localparam int NCH  = 2;
`ifdef MOTOR_ASYM_RAMP_EN
  localparam int DN_STEP = 64;
`else
  localparam int DN_STEP = 16;
`endif
  localparam int ST_DISARMED = 0;
  localparam int ST_ARMING   = 1;
  localparam int ST_ARMED    = 2;
  localparam int ST_FAULT    = 3;

  logic              c50m = 1'b0;
  logic              reset_n;
  logic              cmd_valid;
  logic [NCH*CW-1:0] cmd;
  logic              arm_req;
  logic              brake;
  logic [NCH-1:0]    pwm_out;
  logic [NCH*CW-1:0] ramped_cmd;
  logic [1:0]        drive_state;
  logic              frame_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_pw [NCH];
  int last_pw [NCH];

  esc_multi_drive #(
    .NUM_CH         (NCH),
    .CMD_W          (CW),
    .FRAME_CYC      (FR),
    .PULSE_MIN_CYC  (100),
    .PULSE_SPAN_CYC (100),
    .RAMP_STEP      (16),
`ifdef MOTOR_ASYM_RAMP_EN
    .RAMP_STEP_DN   (64),
`endif
    .ARM_FRAMES     (3),
    .TIMEOUT_FRAMES (4)
  ) dut (
    .c50m        (c50m),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .arm_req     (arm_req),
    .brake       (brake),
    .pwm_out     (pwm_out),
    .ramped_cmd  (ramped_cmd),
    .drive_state (drive_state),
    .frame_tick  (frame_tick)
  );

  always #5 c50m = ~c50m;

  // Measure each frame's pulse length per channel (closed at the next frame tick).
  always @(negedge c50m) begin
    for (int i = 0; i < NCH; i++) begin
      if (!reset_n) begin
        cur_pw[i] <= 0;
      end else if (frame_tick) begin
        last_pw[i] <= cur_pw[i] + int'(pwm_out[i]);
        cur_pw[i]  <= 0;
      end else begin
        cur_pw[i]  <= cur_pw[i] + int'(pwm_out[i]);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic int ramp_ch(input int i);
    return int'(ramped_cmd[i*CW +: CW]);
  endfunction

  task automatic send_cmd(input logic [CW-1:0] c0, input logic [CW-1:0] c1);
    cmd       = {c1, c0};
    cmd_valid = 1'b1;
    @(negedge c50m);
    cmd_valid = 1'b0;
  endtask

  // Stop at the negedge of the next frame_tick cycle.
  task automatic next_tick();
    int n;
    n = 0;
    @(negedge c50m);
    while (frame_tick !== 1'b1 && n < 2*FR + 10) begin
      @(negedge c50m);
      n++;
    end
    if (frame_tick !== 1'b1) check_val("tick_wait", 0, 1);
  endtask

  // Stop one cycle after the next frame start, once the tick decisions are visible.
  task automatic frame();
    next_tick();
    @(negedge c50m);
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd       = '0;
    arm_req   = 1'b0;
    brake     = 1'b0;
    repeat (3) @(negedge c50m);
    check_val("rst_pwm", pwm_out, 0);
    check_val("rst_ramped", ramped_cmd, 0);
    check_val("rst_state", drive_state, ST_DISARMED);
    check_val("rst_tick", frame_tick, 0);
    reset_n = 1'b1;

    // 1. Arming, with an abort in ARMING first.
    arm_req = 1'b1;
    frame();
    check_val("arm_enter", drive_state, ST_ARMING);
    check_val("tick_one_cycle", frame_tick, 0);
    repeat (40) @(negedge c50m);
    check_val("arming_pulse_hi", pwm_out, 3);
    arm_req = 1'b0;
    @(negedge c50m);
    check_val("abort_state", drive_state, ST_DISARMED);
    check_val("abort_pwm", pwm_out, 0);
    arm_req = 1'b1;
    frame();
    check_val("rearm_state", drive_state, ST_ARMING);
    send_cmd(0, 0);
    for (int k = 1; k <= 2; k++) begin
      frame();
      check_val($sformatf("arming_state_f%0d", k), drive_state, ST_ARMING);
      check_val($sformatf("arming_pw0_f%0d", k), last_pw[0], 100);
      check_val($sformatf("arming_pw1_f%0d", k), last_pw[1], 100);
      send_cmd(0, 0);
    end
    frame();
    check_val("armed_state", drive_state, ST_ARMED);
    check_val("arming_pw0_f3", last_pw[0], 100);
    check_val("armed_ramp0", ramp_ch(0), 0);

    // 2. Ramp up to 128 on ch0.
    send_cmd(128, 0);
    for (int k = 1; k <= 8; k++) begin
      frame();
      check_val($sformatf("ramp_up_ch0_k%0d", k), ramp_ch(0), 16*k);
      check_val($sformatf("ramp_up_ch1_k%0d", k), ramp_ch(1), 0);
      send_cmd(128, 0);
    end
    frame();
    check_val("pw_at_128_ch0", last_pw[0], 150);
    check_val("pw_idle_ch1", last_pw[1], 100);
    check_val("hold_128", ramp_ch(0), 128);

    // 3. Full scale without overshoot, then brake and release.
    send_cmd(255, 0);
    for (int k = 1; k <= 8; k++) begin
      frame();
      check_val($sformatf("ramp_full_k%0d", k), ramp_ch(0), (128 + 16*k > 255) ? 255 : 128 + 16*k);
      send_cmd(255, 0);
    end
`ifdef MOTOR_ASYM_RAMP_EN
    send_cmd(0, 0);
    for (int k = 1; k <= 4; k++) begin
      frame();
      check_val($sformatf("asym_dn_k%0d", k), ramp_ch(0), (255 - 64*k < 0) ? 0 : 255 - 64*k);
      send_cmd(0, 0);
    end
    send_cmd(255, 0);
    for (int k = 1; k <= 16; k++) begin
      frame();
      check_val($sformatf("asym_up_k%0d", k), ramp_ch(0), (16*k > 255) ? 255 : 16*k);
      send_cmd(255, 0);
    end
`endif
    frame();
    check_val("pw_at_255", last_pw[0], 199);
    check_val("hold_255", ramp_ch(0), 255);
    brake = 1'b1;
    send_cmd(255, 0);
    frame();
    check_val("brake_ramp0", ramp_ch(0), 0);
    check_val("brake_frame_pw_kept", last_pw[0], 199);
    send_cmd(255, 0);
    frame();
    check_val("brake_pw", last_pw[0], 100);
    brake = 1'b0;
    send_cmd(255, 0);
    frame();
    check_val("release_k1", ramp_ch(0), 16);
    send_cmd(255, 0);
    frame();
    check_val("release_k2", ramp_ch(0), 32);

    // 5. Glitch-free target updates: mid-frame and coincident with the tick.
    send_cmd(32, 0);
    repeat (48) @(negedge c50m);
    send_cmd(32, 64);
    frame();
    check_val("mid_ch0_hold", ramp_ch(0), 32);
    check_val("mid_ch1_applied", ramp_ch(1), 16);
    check_val("mid_ch1_pw_kept", last_pw[1], 100);
    check_val("mid_ch0_pw", last_pw[0], 112);
    next_tick();
    cmd       = {8'd0, 8'd32};
    cmd_valid = 1'b1;
    @(negedge c50m);
    cmd_valid = 1'b0;
    check_val("tick_cmd_old_target", ramp_ch(1), 32);
    check_val("tick_cmd_pw_prev", last_pw[1], 106);
    frame();
    check_val("tick_cmd_applied", ramp_ch(1), (32 > DN_STEP) ? 32 - DN_STEP : 0);
    check_val("tick_cmd_pw_kept", last_pw[1], 112);

    // 4. Timeout: last cmd_valid was at a frame tick, fault on the 4th tick after it.
    frame();
    check_val("to_tick2_state", drive_state, ST_ARMED);
    frame();
    check_val("to_tick3_state", drive_state, ST_ARMED);
    frame();
    check_val("to_tick4_state", drive_state, ST_FAULT);
    check_val("fault_ramped", ramped_cmd, 0);
    frame();
    check_val("fault_pw0", last_pw[0], 100);
    check_val("fault_pw1", last_pw[1], 100);
    send_cmd(0, 0);
    frame();
    check_val("fault_sticky", drive_state, ST_FAULT);
    arm_req = 1'b0;
    @(negedge c50m);
    check_val("fault_exit_state", drive_state, ST_DISARMED);
    check_val("fault_exit_pwm", pwm_out, 0);

    // 6. Asynchronous reset while a pulse is high.
    arm_req = 1'b1;
    frame();
    check_val("rst_test_arming", drive_state, ST_ARMING);
    repeat (59) @(negedge c50m);
    check_val("rst_test_pulse_hi", pwm_out, 3);
    #1 reset_n = 1'b0;
    #1;
    check_val("async_rst_pwm", pwm_out, 0);
    check_val("async_rst_state", drive_state, ST_DISARMED);
    check_val("async_rst_ramped", ramped_cmd, 0);
    check_val("async_rst_tick", frame_tick, 0);
    repeat (3) @(negedge c50m);
    reset_n = 1'b1;
    @(negedge c50m);
    check_val("post_rst_state", drive_state, ST_DISARMED);
    check_val("post_rst_pwm", pwm_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
